// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: decodes framed UART commands into register-file and ALU
// strobes and pushes results to the TX FIFO one byte at a time.
module uart_cmd_ctrl #(
  parameter int data_width    = 8,
  parameter int address_width = 4,
  parameter int alu_fun_width = 4,
  parameter int memory_width  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [data_width-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [data_width-1:0]    RF_RD_DATA,
  input  logic                     RF_RD_VLD,
  input  logic [memory_width-1:0]  ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  input  logic                     FIFO_FULL,
  output logic [address_width-1:0] RF_ADDR,
  output logic                     RF_WR_EN,
  output logic                     RF_RD_EN,
  output logic [data_width-1:0]    RF_WR_DATA,
  output logic [alu_fun_width-1:0] ALU_FUN,
  output logic                     ALU_EN,
  output logic                     CLK_GATE_EN,
  output logic [data_width-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     CMD_ERR
);

  localparam logic [data_width-1:0] CMD_WR  = 8'hAA;
  localparam logic [data_width-1:0] CMD_RD  = 8'hBB;
  localparam logic [data_width-1:0] CMD_ALU = 8'hCC;
  localparam logic [data_width-1:0] CMD_OP  = 8'hDD;

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN,
    ALU_WAIT, TX_LO, TX_HI, TX_RD
  } state_t;

  state_t                     state_q, state_d;
  logic [address_width-1:0]   rf_addr_q, rf_addr_d;
  logic                       rf_wr_en_q, rf_wr_en_d;
  logic                       rf_rd_en_q, rf_rd_en_d;
  logic [data_width-1:0]      rf_wr_data_q, rf_wr_data_d;
  logic [alu_fun_width-1:0]   alu_fun_q, alu_fun_d;
  logic                       alu_en_q, alu_en_d;
  logic                       clk_gate_q, clk_gate_d;
  logic [data_width-1:0]      tx_data_q, tx_data_d;
  logic                       tx_vld_q, tx_vld_d;
  logic                       cmd_err_q, cmd_err_d;
  logic [memory_width-1:0]    result_q, result_d;
  logic [data_width-1:0]      rd_byte_q, rd_byte_d;

  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    clk_gate_d   = clk_gate_q;
    tx_data_d    = tx_data_q;
    result_d     = result_q;
    rd_byte_d    = rd_byte_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    tx_vld_d     = 1'b0;
    cmd_err_d    = 1'b0;
    case (state_q)
      IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          CMD_WR:  state_d = WR_ADDR;
          CMD_RD:  state_d = RD_ADDR;
          CMD_ALU: state_d = OPA;
          CMD_OP:  state_d = FUN;
          default: cmd_err_d = 1'b1;
        endcase
      end
      WR_ADDR: if (RX_D_VLD) begin
        rf_addr_d = RX_P_DATA[address_width-1:0];
        state_d   = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        rf_wr_en_d   = 1'b1;
        rf_wr_data_d = RX_P_DATA;
        state_d      = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        rf_rd_en_d = 1'b1;
        rf_addr_d  = RX_P_DATA[address_width-1:0];
        state_d    = RD_WAIT;
      end
      RD_WAIT: if (RF_RD_VLD) begin
        rd_byte_d = RF_RD_DATA;
        state_d   = TX_RD;
      end
      OPA: if (RX_D_VLD) begin
        rf_wr_en_d   = 1'b1;
        rf_addr_d    = '0;
        rf_wr_data_d = RX_P_DATA;
        state_d      = OPB;
      end
      OPB: if (RX_D_VLD) begin
        rf_wr_en_d   = 1'b1;
        rf_addr_d    = address_width'(1);
        rf_wr_data_d = RX_P_DATA;
        state_d      = FUN;
      end
      // Clock gate opens with the start strobe so the ALU sees its first edge.
      FUN: if (RX_D_VLD) begin
        alu_fun_d  = RX_P_DATA[alu_fun_width-1:0];
        alu_en_d   = 1'b1;
        clk_gate_d = 1'b1;
        state_d    = ALU_WAIT;
      end
      ALU_WAIT: if (ALU_OUT_VLD) begin
        result_d   = ALU_OUT;
        clk_gate_d = 1'b0;
        state_d    = TX_LO;
      end
      TX_LO: if (!FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = result_q[data_width-1:0];
        state_d   = TX_HI;
      end
      TX_HI: if (!FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = result_q[memory_width-1:data_width];
        state_d   = IDLE;
      end
      TX_RD: if (!FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = rd_byte_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      rf_addr_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_wr_data_q <= '0;
      alu_fun_q    <= '0;
      alu_en_q     <= 1'b0;
      clk_gate_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_vld_q     <= 1'b0;
      cmd_err_q    <= 1'b0;
      result_q     <= '0;
      rd_byte_q    <= '0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_fun_q    <= alu_fun_d;
      alu_en_q     <= alu_en_d;
      clk_gate_q   <= clk_gate_d;
      tx_data_q    <= tx_data_d;
      tx_vld_q     <= tx_vld_d;
      cmd_err_q    <= cmd_err_d;
      result_q     <= result_d;
      rd_byte_q    <= rd_byte_d;
    end
  end

  assign RF_ADDR     = rf_addr_q;
  assign RF_WR_EN    = rf_wr_en_q;
  assign RF_RD_EN    = rf_rd_en_q;
  assign RF_WR_DATA  = rf_wr_data_q;
  assign ALU_FUN     = alu_fun_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_GATE_EN = clk_gate_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign CMD_ERR     = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: table of command frames with expected
// strobes/TX bytes, plus hand sequences for back-pressure, clock gate and reset.
module tb_uart_cmd_ctrl;
  logic       CLK = 0, RST = 0;
  logic [7:0] RX_P_DATA = 0, RF_RD_DATA = 0;
  logic       RX_D_VLD = 0, RF_RD_VLD = 0, ALU_OUT_VLD = 0, FIFO_FULL = 0;
  logic [15:0] ALU_OUT = 0;
  logic [3:0] RF_ADDR, ALU_FUN;
  logic       RF_WR_EN, RF_RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD, CMD_ERR;
  logic [7:0] RF_WR_DATA, TX_P_DATA;

  uart_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD), .ALU_OUT(ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL), .RF_ADDR(RF_ADDR),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_WR_DATA(RF_WR_DATA),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR));

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  logic [7:0] wa_q[$], wd_q[$], tx_q[$];
  int rd_cnt, alu_cnt, err_cnt, rd_cd, alu_cd;
  logic [3:0] rd_addr, last_fun;
  logic [15:0] resp;

  typedef struct {
    int n; logic [7:0] b[4]; logic [15:0] resp;
    int e_wr; logic [7:0] wa0, wd0, wa1, wd1;
    int e_rd; logic [7:0] ra;
    int e_alu; logic [7:0] fun;
    int e_tx; logic [7:0] t0, t1;
    int e_err;
  } vec_t;
  vec_t vecs[7];

  function automatic vec_t mk(int n, logic [7:0] b0, b1, b2, b3, logic [15:0] r,
                              int ewr, logic [7:0] wa0, wd0, wa1, wd1,
                              int erd, logic [7:0] ra, int ealu, logic [7:0] fun,
                              int etx, logic [7:0] t0, t1, int eerr);
    vec_t v;
    v.n = n; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.resp = r;
    v.e_wr = ewr; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.e_rd = erd; v.ra = ra; v.e_alu = ealu; v.fun = fun;
    v.e_tx = etx; v.t0 = t0; v.t1 = t1; v.e_err = eerr;
    return v;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  task automatic clr();
    wa_q.delete(); wd_q.delete(); tx_q.delete();
    rd_cnt = 0; alu_cnt = 0; err_cnt = 0; rd_cd = 0; alu_cd = 0;
    rd_addr = 0; last_fun = 0;
  endtask

  // One clock: sample registered outputs just after the edge, then drive the
  // RF/ALU responders that answer RF_RD_EN / ALU_EN a few cycles later.
  task automatic step();
    @(posedge CLK); #1;
    RX_D_VLD = 0; RF_RD_VLD = 0; ALU_OUT_VLD = 0;
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0) begin RF_RD_DATA = resp[7:0]; RF_RD_VLD = 1; end
    end
    if (alu_cd > 0) begin
      alu_cd--;
      if (alu_cd == 0) begin ALU_OUT = resp; ALU_OUT_VLD = 1; end
    end
    if (RF_WR_EN) begin wa_q.push_back({4'h0, RF_ADDR}); wd_q.push_back(RF_WR_DATA); end
    if (RF_RD_EN) begin rd_cnt++; rd_addr = RF_ADDR; rd_cd = 2; end
    if (ALU_EN)   begin alu_cnt++; last_fun = ALU_FUN; alu_cd = 3; end
    if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
    if (CMD_ERR)  err_cnt++;
  endtask

  task automatic send(logic [7:0] b);
    RX_P_DATA = b; RX_D_VLD = 1;
    step();
  endtask

  function automatic logic [7:0] qget(logic [7:0] q[$], int i);
    return (q.size() > i) ? q[i] : 8'hxx;
  endfunction

  initial begin
    vecs[0] = mk(3, 8'hAA, 8'h05, 8'hA6, 8'h00, 16'h0000, 1, 8'h05, 8'hA6, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1] = mk(2, 8'hBB, 8'h05, 0, 0, 16'h00A6, 0, 0, 0, 0, 0,
                 1, 8'h05, 0, 0, 1, 8'hA6, 0, 0);
    vecs[2] = mk(4, 8'hCC, 8'h35, 8'h88, 8'h02, 16'h1C28, 2, 8'h00, 8'h35, 8'h01, 8'h88,
                 0, 0, 1, 8'h02, 2, 8'h28, 8'h1C, 0);
    vecs[3] = mk(2, 8'hDD, 8'h07, 0, 0, 16'h00FF, 0, 0, 0, 0, 0,
                 0, 0, 1, 8'h07, 2, 8'hFF, 8'h00, 0);
    vecs[4] = mk(1, 8'h55, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[5] = mk(3, 8'hAA, 8'hF3, 8'h11, 0, 16'h0000, 1, 8'h03, 8'h11, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6] = mk(2, 8'hBB, 8'h1E, 0, 0, 16'h005A, 0, 0, 0, 0, 0,
                 1, 8'h0E, 0, 0, 1, 8'h5A, 0, 0);

    clr(); resp = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset outs", {RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_FUN, ALU_EN,
                       CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
    RST = 1;
    step();

    for (int i = 0; i < 7; i++) begin
      clr(); resp = vecs[i].resp;
      for (int j = 0; j < vecs[i].n; j++) begin
        send(vecs[i].b[j]);
        step();
      end
      repeat (15) step();
      chk($sformatf("v%0d wr_cnt", i), wa_q.size(), vecs[i].e_wr);
      if (vecs[i].e_wr > 0) begin
        chk($sformatf("v%0d wa0", i), qget(wa_q, 0), vecs[i].wa0);
        chk($sformatf("v%0d wd0", i), qget(wd_q, 0), vecs[i].wd0);
      end
      if (vecs[i].e_wr > 1) begin
        chk($sformatf("v%0d wa1", i), qget(wa_q, 1), vecs[i].wa1);
        chk($sformatf("v%0d wd1", i), qget(wd_q, 1), vecs[i].wd1);
      end
      chk($sformatf("v%0d rd_cnt", i), rd_cnt, vecs[i].e_rd);
      if (vecs[i].e_rd > 0) chk($sformatf("v%0d rd_addr", i), rd_addr, vecs[i].ra);
      chk($sformatf("v%0d alu_cnt", i), alu_cnt, vecs[i].e_alu);
      if (vecs[i].e_alu > 0) chk($sformatf("v%0d fun", i), last_fun, vecs[i].fun);
      chk($sformatf("v%0d tx_cnt", i), tx_q.size(), vecs[i].e_tx);
      if (vecs[i].e_tx > 0) chk($sformatf("v%0d tx0", i), qget(tx_q, 0), vecs[i].t0);
      if (vecs[i].e_tx > 1) chk($sformatf("v%0d tx1", i), qget(tx_q, 1), vecs[i].t1);
      chk($sformatf("v%0d err_cnt", i), err_cnt, vecs[i].e_err);
      chk($sformatf("v%0d gate_off", i), CLK_GATE_EN, 0);
    end

    // FIFO back-pressure across ALU_WAIT and into TX_LO.
    clr(); resp = 16'h1C28; FIFO_FULL = 1;
    send(8'hCC); send(8'h35); send(8'h88); send(8'h02);
    repeat (10) step();
    chk("full no_push", tx_q.size(), 0);
    FIFO_FULL = 0;
    repeat (10) step();
    chk("full tx_cnt", tx_q.size(), 2);
    chk("full tx0", qget(tx_q, 0), 8'h28);
    chk("full tx1", qget(tx_q, 1), 8'h1C);

    // Clock-gate timing and a stray byte dropped during ALU_WAIT.
    clr(); resp = 16'h1234;
    send(8'hDD); send(8'h02);
    chk("gate rise", {ALU_EN, CLK_GATE_EN, ALU_FUN}, {2'b11, 4'h2});
    send(8'hAA); step(); step();
    chk("gate held", CLK_GATE_EN, 1);
    step();
    chk("gate fall", CLK_GATE_EN, 0);
    repeat (10) step();
    chk("stray wr", wa_q.size(), 0);
    chk("stray tx_cnt", tx_q.size(), 2);
    chk("stray tx0", qget(tx_q, 0), 8'h34);
    chk("stray tx1", qget(tx_q, 1), 8'h12);

    // Reset while waiting on the ALU.
    clr(); resp = 16'hBEEF;
    send(8'hDD); send(8'h05); step();
    RST = 0; #1;
    chk("rst outs", {RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_FUN, ALU_EN,
                     CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
    step();
    RST = 1;
    repeat (10) step();
    chk("rst no_push", tx_q.size(), 0);

    // Unknown byte straight after reset: only CMD_ERR moves.
    clr();
    send(8'h55);
    chk("err pulse", {RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_FUN, ALU_EN,
                      CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 1);
    step();
    chk("err width", CMD_ERR, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
